// File: rtl/pacman_pkg.sv
// Shared constants and draw-state encoding for the Pac-Man sprite path.
// Screen geometry, tile size and the arbiter FSM states live here.
package pacman_pkg;

  localparam int TILE     = 5;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAW,
    ST_DONE
  } draw_state_e;

  // Cell coordinate to top-left pixel coordinate.
  function automatic logic [7:0] cell_to_px(
    input logic [4:0] c
  );
    return {3'b000, c} * 8'(TILE);
  endfunction

endpackage

// File: rtl/sprite_draw_arbiter_rr.sv
// Combinational round-robin pick among sprite requesters.
// Search begins one past the previous grant and wraps around.
module rr_arbiter
  import pacman_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] winner
);

  logic [IW-1:0] idx;
  logic          found;

  // First active request after last_grant wins.
  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(last_grant) + k) % N_REQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_draw_arbiter.sv
// Shares the 5x5 sprite raster and the VGA plot port among requesters.
// Grants one sprite at a time and scans its 25 pixels row-major.
module sprite_draw_arbiter
  import pacman_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [5*N_REQ-1:0] req_cx,
  input  logic [5*N_REQ-1:0] req_cy,
  input  logic [25*N_REQ-1:0] req_shape,
  input  logic [3*N_REQ-1:0] req_colour,
  output logic [N_REQ-1:0]   grant,
  output logic               done,
  output logic               busy,
  output logic               plot,
  output logic [7:0]         x,
  output logic [6:0]         y,
  output logic [2:0]         colour
);

  localparam int IW = $clog2(N_REQ);

  draw_state_e   state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] win_q, win_d;
  logic [7:0]    bx_q, bx_d;
  logic [7:0]    by_q, by_d;
  logic [24:0]   shp_q, shp_d;
  logic [2:0]    clr_q, clr_d;
  logic [2:0]    col_q, col_d;
  logic [2:0]    row_q, row_d;

  logic [N_REQ-1:0] arb_win;
  logic [IW-1:0]    arb_idx;
  logic [4:0]       sel_cx, sel_cy;
  logic [24:0]      sel_shp;
  logic [2:0]       sel_clr;
  logic [7:0]       py;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req),
    .last_grant(last_q),
    .winner    (arb_win)
  );

  // One-hot arbiter result to requester index.
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_win[i]) arb_idx = IW'(i);
    end
  end

  // Route the recorded winner's packed fields.
  always_comb begin
    sel_cx  = '0;
    sel_cy  = '0;
    sel_shp = '0;
    sel_clr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_q == IW'(i)) begin
        sel_cx  = req_cx[i*5 +: 5];
        sel_cy  = req_cy[i*5 +: 5];
        sel_shp = req_shape[i*25 +: 25];
        sel_clr = req_colour[i*3 +: 3];
      end
    end
  end

  // Next state: arbitrate, latch, raster scan, done.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    bx_d    = bx_q;
    by_d    = by_q;
    shp_d   = shp_q;
    clr_d   = clr_q;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          win_d   = arb_idx;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bx_d    = cell_to_px(sel_cx);
        by_d    = cell_to_px(sel_cy);
        shp_d   = sel_shp;
        clr_d   = sel_clr;
        col_d   = '0;
        row_d   = '0;
        last_d  = win_q;
        state_d = ST_DRAW;
      end
      ST_DRAW: begin
        // Shape shifts so bit 24 is always the current pixel.
        shp_d = {shp_q[23:0], 1'b0};
        if (col_q == 3'd4) begin
          col_d = '0;
          if (row_q == 3'd4) begin
            row_d   = '0;
            state_d = ST_DONE;
          end else begin
            row_d = row_q + 3'd1;
          end
        end else begin
          col_d = col_q + 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pixel and handshake outputs from registered state.
  always_comb begin
    grant  = '0;
    done   = 1'b0;
    busy   = (state_q != ST_IDLE);
    plot   = 1'b0;
    x      = '0;
    y      = '0;
    colour = COLOUR_BLACK;
    py     = by_q + {5'b00000, row_q};
    if (state_q != ST_IDLE) grant[win_q] = 1'b1;
    if (state_q == ST_DONE) done = 1'b1;
    if (state_q == ST_DRAW) begin
      x      = bx_q + {5'b00000, col_q};
      y      = py[6:0];
      plot   = (py < 8'(SCREEN_H));
      colour = shp_q[24] ? clr_q : COLOUR_BLACK;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= IW'(N_REQ - 1);
      win_q   <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      shp_q   <= '0;
      clr_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      shp_q   <= shp_d;
      clr_q   <= clr_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// Directed bench for sprite_draw_arbiter.
// Expected pixels are queued at request time and popped per DRAW cycle.
module tb_sprite_draw_arbiter;

  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req;
  logic [5*N-1:0] req_cx;
  logic [5*N-1:0] req_cy;
  logic [25*N-1:0] req_shape;
  logic [3*N-1:0] req_colour;
  logic [N-1:0]   grant;
  logic           done;
  logic           busy;
  logic           plot;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       p;
  } px_t;

  px_t sb[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  sprite_draw_arbiter #(.N_REQ(N)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .req_cx    (req_cx),
    .req_cy    (req_cy),
    .req_shape (req_shape),
    .req_colour(req_colour),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .plot      (plot),
    .x         (x),
    .y         (y),
    .colour    (colour)
  );

  always #5 clock = ~clock;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_src(
    input int          i,
    input logic [4:0]  cx,
    input logic [4:0]  cy,
    input logic [24:0] shp,
    input logic [2:0]  c
  );
    req_cx[i*5 +: 5]      = cx;
    req_cy[i*5 +: 5]      = cy;
    req_shape[i*25 +: 25] = shp;
    req_colour[i*3 +: 3]  = c;
  endtask

  task automatic push_sprite(input int i);
    logic [4:0]  cx;
    logic [4:0]  cy;
    logic [24:0] shp;
    logic [2:0]  c;
    px_t         p;
    int          ex, ey, bi;
    cx  = req_cx[i*5 +: 5];
    cy  = req_cy[i*5 +: 5];
    shp = req_shape[i*25 +: 25];
    c   = req_colour[i*3 +: 3];
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 5; k++) begin
        ex  = int'(cx) * 5 + k;
        ey  = int'(cy) * 5 + r;
        bi  = 24 - (5 * r + k);
        p.x = 8'(ex);
        p.y = 7'(ey);
        p.p = (ey < 120);
        p.c = shp[bi] ? c : 3'b000;
        sb.push_back(p);
      end
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_plot"}, 32'(plot), 0);
    chk({tag, "_x"}, 32'(x), 0);
    chk({tag, "_y"}, 32'(y), 0);
    chk({tag, "_colour"}, 32'(colour), 0);
  endtask

  // Called at #1 after an edge with the DUT idle and req set.
  task automatic draw_check(input int id, input int chg_at);
    px_t e;
    push_sprite(id);
    step();
    chk("load_grant", 32'(grant), 32'(1) << id);
    chk("load_busy", 32'(busy), 1);
    chk("load_plot", 32'(plot), 0);
    for (int k = 0; k < 25; k++) begin
      step();
      e = sb.pop_front();
      chk("px_x", 32'(x), 32'(e.x));
      chk("px_y", 32'(y), 32'(e.y));
      chk("px_colour", 32'(colour), 32'(e.c));
      chk("px_plot", 32'(plot), 32'(e.p));
      chk("px_grant", 32'(grant), 32'(1) << id);
      chk("px_done", 32'(done), 0);
      if (k == chg_at) begin
        req = '0;
        req_cx[id*5 +: 5] = ~req_cx[id*5 +: 5];
      end
    end
    step();
    chk("done_pulse", 32'(done), 1);
    chk("done_grant", 32'(grant), 32'(1) << id);
    chk("done_plot", 32'(plot), 0);
    step();
    chk("idle_done", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_grant", 32'(grant), 0);
  endtask

  initial begin
    req        = '0;
    req_cx     = '0;
    req_cy     = '0;
    req_shape  = '0;
    req_colour = '0;
    reset_n    = 1'b0;
    #1;
    chk_quiet("rst");
    step();
    step();
    reset_n = 1'b1;

    set_src(0, 5'd2, 5'd3, 25'h1FFFFFF, 3'b110);
    req = 4'b0001;
    draw_check(0, -1);
    req = '0;
    step();
    chk_quiet("after_t1");

    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    set_src(0, 5'd1, 5'd1, 25'h1F00000, 3'b001);
    set_src(1, 5'd5, 5'd2, 25'h0A5A5A5, 3'b010);
    set_src(2, 5'd9, 5'd6, 25'h1111111, 3'b011);
    set_src(3, 5'd20, 5'd10, 25'h00FFF00, 3'b100);
    req = 4'b1111;
    draw_check(0, -1);
    draw_check(1, -1);
    draw_check(2, -1);
    draw_check(3, -1);
    draw_check(0, -1);
    req = '0;

    set_src(1, 5'd0, 5'd0, 25'h1000000, 3'b101);
    req = 4'b0010;
    draw_check(1, -1);
    req = '0;

    set_src(2, 5'd31, 5'd23, 25'h1555555, 3'b011);
    req = 4'b0100;
    draw_check(2, -1);
    req = '0;

    set_src(3, 5'd31, 5'd24, 25'h1FFFFFF, 3'b111);
    req = 4'b1000;
    draw_check(3, -1);
    req = '0;

    set_src(0, 5'd4, 5'd4, 25'h1FFFFFF, 3'b010);
    req = 4'b0001;
    step();
    chk("mid_load_grant", 32'(grant), 1);
    repeat (10) step();
    chk("mid_plot", 32'(plot), 1);
    chk("mid_x", 32'(x), 24);
    reset_n = 1'b0;
    req = '0;
    #1;
    chk_quiet("mid_rst");
    step();
    chk_quiet("mid_rst_hold");
    reset_n = 1'b1;
    set_src(2, 5'd12, 5'd7, 25'h1C71C71, 3'b110);
    req = 4'b0100;
    draw_check(2, -1);
    req = '0;

    set_src(1, 5'd7, 5'd8, 25'h0F0F0F0, 3'b100);
    req = 4'b0010;
    draw_check(1, 3);
    step();
    chk_quiet("drop_idle1");
    step();
    chk_quiet("drop_idle2");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
